// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types and constants.
// Holds the permutation controller op kinds, FSM states and request bundles.
package riscv_v_pkg;

   localparam int RISCV_DATA_WIDTH = 32;
   localparam int RISCV_V_VLEN     = 128;
   localparam int BYTE_WIDTH       = 8;
   localparam int RISCV_XREG_W     = 5;
   localparam int RISCV_VREG_W     = 5;

   typedef enum logic {
      PERM_I2V,
      PERM_V2I
   } riscv_v_perm_kind_e;

   typedef enum logic [1:0] {
      PERM_IDLE,
      PERM_EXEC,
      PERM_WB
   } riscv_v_perm_state_e;

   typedef struct packed {
      logic [RISCV_DATA_WIDTH-1:0] data;
      logic [RISCV_VREG_W-1:0]     vd;
   } riscv_v_perm_i2v_req_t;

   typedef struct packed {
      logic [RISCV_V_VLEN-1:0] data;
      logic [RISCV_XREG_W-1:0] rd;
   } riscv_v_perm_v2i_req_t;

endpackage

// File: rtl/riscv_v_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner
// and moves only when a grant is actually taken (en_i high).
module riscv_v_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
         gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
      end
      last_d = last_q;
      if (|gnt_o) begin
         last_d = gnt_o[1];
      end
   end

   // Reset as if requester 1 won last, so requester 0 goes first.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/riscv_v_permutation_ctrl.sv
// Sequencer for vmv.s.x / vmv.x.s through the permutation ALU.
// One op in flight: IDLE -> EXEC -> WB, with WB->EXEC chaining.
module riscv_v_permutation_ctrl
   import riscv_v_pkg::*;
#(
   parameter int DATA_W = RISCV_DATA_WIDTH,
   parameter int VLEN   = RISCV_V_VLEN,
   parameter int XREG_W = 5,
   parameter int VREG_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i2v_req_valid,
   output logic                       i2v_req_ready,
   input  logic [DATA_W-1:0]          i2v_req_data,
   input  logic [VREG_W-1:0]          i2v_req_vd,
   input  logic                       v2i_req_valid,
   output logic                       v2i_req_ready,
   input  logic [VLEN-1:0]            v2i_req_data,
   input  logic [XREG_W-1:0]          v2i_req_rd,
   output logic                       alu_is_i2v,
   output logic                       alu_is_v2i,
   output logic [DATA_W-1:0]          alu_int_in,
   output logic [VLEN-1:0]            alu_vec_in,
   input  logic [DATA_W-1:0]          alu_int_out,
   input  logic [VLEN-1:0]            alu_vec_out_data,
   input  logic [VLEN/BYTE_WIDTH-1:0] alu_vec_out_valid,
   output logic                       xwb_valid,
   input  logic                       xwb_ready,
   output logic [XREG_W-1:0]          xwb_rd,
   output logic [DATA_W-1:0]          xwb_data,
   output logic                       vwb_valid,
   input  logic                       vwb_ready,
   output logic [VREG_W-1:0]          vwb_vd,
   output logic [VLEN-1:0]            vwb_data,
   output logic [VLEN/BYTE_WIDTH-1:0] vwb_be,
   input  logic                       flush,
   output logic                       busy
);

   localparam int BE_W = VLEN / BYTE_WIDTH;

   riscv_v_perm_state_e state_q;
   riscv_v_perm_kind_e  kind_q;
   riscv_v_perm_kind_e  kind_d;

   logic [DATA_W-1:0] int_op_q, int_op_d;
   logic [VLEN-1:0]   vec_op_q, vec_op_d;
   logic [VREG_W-1:0] vd_q, vd_d;
   logic [XREG_W-1:0] rd_q, rd_d;
   logic              is_i2v_q, is_v2i_q;

   logic              xwb_valid_q;
   logic [XREG_W-1:0] xwb_rd_q;
   logic [DATA_W-1:0] xwb_data_q;
   logic              vwb_valid_q;
   logic [VREG_W-1:0] vwb_vd_q;
   logic [VLEN-1:0]   vwb_data_q;
   logic [BE_W-1:0]   vwb_be_q;

   logic       wb_ready;
   logic       wb_done;
   logic       accept_win;
   logic       accept;
   logic [1:0] gnt;

   // Handshake terms never look at data, only state, valids and readys.
   always_comb begin
      wb_ready   = (kind_q == PERM_V2I) ? xwb_ready : vwb_ready;
      wb_done    = (state_q == PERM_WB) & wb_ready & ~flush;
      accept_win = ~rst & ((state_q == PERM_IDLE) | wb_done);
   end

   riscv_v_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i ({v2i_req_valid, i2v_req_valid}),
      .en_i  (accept_win),
      .gnt_o (gnt)
   );

   assign i2v_req_ready = gnt[0];
   assign v2i_req_ready = gnt[1];
   assign accept        = |gnt;

   always_comb begin
      kind_d   = gnt[1] ? PERM_V2I : PERM_I2V;
      int_op_d = gnt[0] ? i2v_req_data : '0;
      vec_op_d = gnt[1] ? v2i_req_data : '0;
      vd_d     = gnt[0] ? i2v_req_vd : '0;
      rd_d     = gnt[1] ? v2i_req_rd : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PERM_IDLE;
         kind_q      <= PERM_I2V;
         int_op_q    <= '0;
         vec_op_q    <= '0;
         vd_q        <= '0;
         rd_q        <= '0;
         is_i2v_q    <= 1'b0;
         is_v2i_q    <= 1'b0;
         xwb_valid_q <= 1'b0;
         xwb_rd_q    <= '0;
         xwb_data_q  <= '0;
         vwb_valid_q <= 1'b0;
         vwb_vd_q    <= '0;
         vwb_data_q  <= '0;
         vwb_be_q    <= '0;
      end else begin
         is_i2v_q <= 1'b0;
         is_v2i_q <= 1'b0;
         if (accept) begin
            kind_q   <= kind_d;
            int_op_q <= int_op_d;
            vec_op_q <= vec_op_d;
            vd_q     <= vd_d;
            rd_q     <= rd_d;
            is_i2v_q <= gnt[0];
            is_v2i_q <= gnt[1];
         end
         unique case (state_q)
            PERM_IDLE: begin
               if (accept) begin
                  state_q <= PERM_EXEC;
               end
            end
            PERM_EXEC: begin
               if (flush) begin
                  state_q <= PERM_IDLE;
               end else begin
                  state_q <= PERM_WB;
                  if (kind_q == PERM_V2I) begin
                     xwb_valid_q <= 1'b1;
                     xwb_rd_q    <= rd_q;
                     xwb_data_q  <= alu_int_out;
                  end else begin
                     vwb_valid_q <= 1'b1;
                     vwb_vd_q    <= vd_q;
                     vwb_data_q  <= alu_vec_out_data;
                     vwb_be_q    <= alu_vec_out_valid;
                  end
               end
            end
            PERM_WB: begin
               // Leaving WB either way empties both ports back to zero.
               if (flush | wb_done) begin
                  xwb_valid_q <= 1'b0;
                  xwb_rd_q    <= '0;
                  xwb_data_q  <= '0;
                  vwb_valid_q <= 1'b0;
                  vwb_vd_q    <= '0;
                  vwb_data_q  <= '0;
                  vwb_be_q    <= '0;
                  state_q     <= accept ? PERM_EXEC : PERM_IDLE;
               end
            end
            default: begin
               state_q <= PERM_IDLE;
            end
         endcase
      end
   end

   assign alu_is_i2v = is_i2v_q;
   assign alu_is_v2i = is_v2i_q;
   assign alu_int_in = (state_q == PERM_EXEC) ? int_op_q : '0;
   assign alu_vec_in = (state_q == PERM_EXEC) ? vec_op_q : '0;

   assign xwb_valid = xwb_valid_q;
   assign xwb_rd    = xwb_rd_q;
   assign xwb_data  = xwb_data_q;
   assign vwb_valid = vwb_valid_q;
   assign vwb_vd    = vwb_vd_q;
   assign vwb_data  = vwb_data_q;
   assign vwb_be    = vwb_be_q;
   assign busy      = (state_q != PERM_IDLE);

endmodule

// File: tb/tb_riscv_v_permutation_ctrl.sv
// Scoreboard bench for the permutation controller with a behavioural ALU.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_riscv_v_permutation_ctrl;
   import riscv_v_pkg::*;

   localparam int DW = 32;
   localparam int VL = 128;
   localparam int BW = VL / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i2v_req_valid = 1'b0;
   logic          i2v_req_ready;
   logic [DW-1:0] i2v_req_data = '0;
   logic [4:0]    i2v_req_vd = '0;
   logic          v2i_req_valid = 1'b0;
   logic          v2i_req_ready;
   logic [VL-1:0] v2i_req_data = '0;
   logic [4:0]    v2i_req_rd = '0;
   logic          alu_is_i2v, alu_is_v2i;
   logic [DW-1:0] alu_int_in, alu_int_out;
   logic [VL-1:0] alu_vec_in, alu_vec_out_data;
   logic [BW-1:0] alu_vec_out_valid;
   logic          xwb_valid;
   logic          xwb_ready = 1'b1;
   logic [4:0]    xwb_rd;
   logic [DW-1:0] xwb_data;
   logic          vwb_valid;
   logic          vwb_ready = 1'b1;
   logic [4:0]    vwb_vd;
   logic [VL-1:0] vwb_data;
   logic [BW-1:0] vwb_be;
   logic          flush = 1'b0;
   logic          busy;

   typedef struct {
      riscv_v_perm_kind_e kind;
      logic [4:0]         idx;
      logic [VL-1:0]      data;
      logic [BW-1:0]      be;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural permutation ALU: scalar<->element 0 moves.
   assign alu_int_out       = alu_vec_in[DW-1:0];
   assign alu_vec_out_data  = {{(VL-DW){1'b0}}, alu_int_in};
   assign alu_vec_out_valid = alu_is_i2v ? 16'h000F : 16'h0000;

   riscv_v_permutation_ctrl dut (
      .clk(clk), .rst(rst),
      .i2v_req_valid(i2v_req_valid), .i2v_req_ready(i2v_req_ready),
      .i2v_req_data(i2v_req_data), .i2v_req_vd(i2v_req_vd),
      .v2i_req_valid(v2i_req_valid), .v2i_req_ready(v2i_req_ready),
      .v2i_req_data(v2i_req_data), .v2i_req_rd(v2i_req_rd),
      .alu_is_i2v(alu_is_i2v), .alu_is_v2i(alu_is_v2i),
      .alu_int_in(alu_int_in), .alu_vec_in(alu_vec_in),
      .alu_int_out(alu_int_out), .alu_vec_out_data(alu_vec_out_data),
      .alu_vec_out_valid(alu_vec_out_valid),
      .xwb_valid(xwb_valid), .xwb_ready(xwb_ready),
      .xwb_rd(xwb_rd), .xwb_data(xwb_data),
      .vwb_valid(vwb_valid), .vwb_ready(vwb_ready),
      .vwb_vd(vwb_vd), .vwb_data(vwb_data), .vwb_be(vwb_be),
      .flush(flush), .busy(busy)
   );

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (flush && busy) begin
            if (sb.size() > 0) void'(sb.pop_front());
         end else if (xwb_valid && xwb_ready) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL xwb_unexpected rd=%0d data=%h, required none", xwb_rd, xwb_data);
            end else begin
               e = sb.pop_front();
               if (e.kind !== PERM_V2I || e.idx !== xwb_rd || e.data[DW-1:0] !== xwb_data
                   || vwb_data !== '0 || vwb_be !== '0 || vwb_vd !== '0) begin
                  fails++;
                  $display("FAIL xwb_result got rd=%0d data=%h vwb_be=%h, required kind=%s rd=%0d data=%h",
                           xwb_rd, xwb_data, vwb_be, e.kind.name(), e.idx, e.data[DW-1:0]);
               end
            end
         end else if (vwb_valid && vwb_ready) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL vwb_unexpected vd=%0d data=%h, required none", vwb_vd, vwb_data);
            end else begin
               e = sb.pop_front();
               if (e.kind !== PERM_I2V || e.idx !== vwb_vd || e.data !== vwb_data
                   || e.be !== vwb_be || xwb_data !== '0 || xwb_rd !== '0) begin
                  fails++;
                  $display("FAIL vwb_result got vd=%0d data=%h be=%h, required kind=%s vd=%0d data=%h be=%h",
                           vwb_vd, vwb_data, vwb_be, e.kind.name(), e.idx, e.data, e.be);
               end
            end
         end
         if (i2v_req_valid && i2v_req_ready) begin
            e.kind = PERM_I2V;
            e.idx  = i2v_req_vd;
            e.data = {{(VL-DW){1'b0}}, i2v_req_data};
            e.be   = 16'h000F;
            sb.push_back(e);
         end
         if (v2i_req_valid && v2i_req_ready) begin
            e.kind = PERM_V2I;
            e.idx  = v2i_req_rd;
            e.data = {{(VL-DW){1'b0}}, v2i_req_data[DW-1:0]};
            e.be   = '0;
            sb.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL %s_timeout busy=%b, required 0", name, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i2v_req_valid = 1'b1;
      v2i_req_valid = 1'b1;
      step();
      step();
      @(negedge clk);
      tests++;
      if ({busy, xwb_valid, vwb_valid, alu_is_i2v, alu_is_v2i, i2v_req_ready, v2i_req_ready} !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl got busy=%b xv=%b vv=%b i2v=%b v2i=%b rdy=%b%b, required all 0",
                  busy, xwb_valid, vwb_valid, alu_is_i2v, alu_is_v2i, i2v_req_ready, v2i_req_ready);
      end
      tests++;
      if (xwb_data !== '0 || vwb_data !== '0 || vwb_be !== '0 || xwb_rd !== '0 || vwb_vd !== '0) begin
         fails++;
         $display("FAIL reset_data got xd=%h vd=%h be=%h, required 0", xwb_data, vwb_data, vwb_be);
      end
      step();
      rst = 1'b0;
      i2v_req_valid = 1'b0;
      v2i_req_valid = 1'b0;
   endtask

   task automatic test_i2v();
      vwb_ready = 1'b1;
      i2v_req_valid = 1'b1;
      i2v_req_data = 32'hDEADBEEF;
      i2v_req_vd = 5'd3;
      @(negedge clk);
      tests++;
      if ({i2v_req_ready, v2i_req_ready, busy} !== 3'b100) begin
         fails++;
         $display("FAIL i2v_accept got rdy=%b%b busy=%b, required 1 0 0", i2v_req_ready, v2i_req_ready, busy);
      end
      step();
      i2v_req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, alu_is_i2v, alu_is_v2i, vwb_valid} !== 4'b1100 || alu_int_in !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL i2v_exec got busy=%b i2v=%b v2i=%b vv=%b int_in=%h, required 1 1 0 0 deadbeef",
                  busy, alu_is_i2v, alu_is_v2i, vwb_valid, alu_int_in);
      end
      step();
      @(negedge clk);
      tests++;
      if ({vwb_valid, busy, xwb_valid, alu_is_i2v} !== 4'b1100 || vwb_be !== 16'h000F
          || vwb_vd !== 5'd3 || vwb_data !== {96'h0, 32'hDEADBEEF}) begin
         fails++;
         $display("FAIL i2v_wb got vv=%b busy=%b be=%h vd=%0d data=%h, required 1 1 000f 3 deadbeef",
                  vwb_valid, busy, vwb_be, vwb_vd, vwb_data);
      end
      step();
      @(negedge clk);
      tests++;
      if ({busy, vwb_valid} !== 2'b00) begin
         fails++;
         $display("FAIL i2v_done got busy=%b vv=%b, required 0 0", busy, vwb_valid);
      end
      step();
   endtask

   task automatic test_v2i();
      logic [VL-1:0] vs2;
      vs2 = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h12345678};
      xwb_ready = 1'b1;
      v2i_req_valid = 1'b1;
      v2i_req_data = vs2;
      v2i_req_rd = 5'd7;
      @(negedge clk);
      tests++;
      if ({v2i_req_ready, i2v_req_ready, alu_is_v2i} !== 3'b100) begin
         fails++;
         $display("FAIL v2i_accept got rdy=%b is_v2i=%b, required 1 0", v2i_req_ready, alu_is_v2i);
      end
      step();
      v2i_req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, alu_is_v2i, alu_is_i2v} !== 3'b110 || alu_vec_in !== vs2 || alu_int_in !== '0) begin
         fails++;
         $display("FAIL v2i_exec got busy=%b v2i=%b i2v=%b vec_in=%h, required 1 1 0 %h",
                  busy, alu_is_v2i, alu_is_i2v, alu_vec_in, vs2);
      end
      step();
      @(negedge clk);
      tests++;
      if ({xwb_valid, alu_is_v2i, vwb_valid} !== 3'b100 || xwb_data !== 32'h12345678
          || xwb_rd !== 5'd7 || vwb_data !== '0 || vwb_be !== '0) begin
         fails++;
         $display("FAIL v2i_wb got xv=%b is_v2i=%b data=%h rd=%0d, required 1 0 12345678 7",
                  xwb_valid, alu_is_v2i, xwb_data, xwb_rd);
      end
      step();
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL v2i_done got busy=%b, required 0", busy);
      end
      step();
   endtask

   task automatic test_back_to_back();
      riscv_v_perm_kind_e kinds[$];
      int when[$];
      riscv_v_perm_kind_e want;
      vwb_ready = 1'b1;
      xwb_ready = 1'b1;
      i2v_req_valid = 1'b1;
      v2i_req_valid = 1'b1;
      i2v_req_data = $urandom;
      i2v_req_vd = 5'd10;
      v2i_req_data = {$urandom, $urandom, $urandom, $urandom};
      v2i_req_rd = 5'd20;
      for (int c = 0; c < 20 && kinds.size() < 4; c++) begin
         @(negedge clk);
         if (i2v_req_ready) begin
            kinds.push_back(PERM_I2V);
            when.push_back(cyc);
         end
         if (v2i_req_ready) begin
            kinds.push_back(PERM_V2I);
            when.push_back(cyc);
         end
         step();
         i2v_req_data = $urandom;
         v2i_req_data = {$urandom, $urandom, $urandom, $urandom};
         if (kinds.size() >= 4) begin
            i2v_req_valid = 1'b0;
            v2i_req_valid = 1'b0;
         end
      end
      i2v_req_valid = 1'b0;
      v2i_req_valid = 1'b0;
      tests++;
      if (kinds.size() != 4) begin
         fails++;
         $display("FAIL b2b_count got %0d, required 4", kinds.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? PERM_I2V : PERM_V2I;
            tests++;
            if (kinds[k] !== want) begin
               fails++;
               $display("FAIL b2b_grant%0d got %s, required %s", k, kinds[k].name(), want.name());
            end
         end
         for (int k = 1; k < 4; k++) begin
            tests++;
            if (when[k] - when[k-1] != 2) begin
               fails++;
               $display("FAIL b2b_gap%0d got %0d, required 2", k, when[k] - when[k-1]);
            end
         end
      end
      wait_idle("b2b");
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] snap_d;
      logic [4:0]    snap_r;
      logic [DW-1:0] lo;
      xwb_ready = 1'b0;
      vwb_ready = 1'b1;
      v2i_req_valid = 1'b1;
      v2i_req_data = {$urandom, $urandom, $urandom, $urandom};
      lo = v2i_req_data[DW-1:0];
      v2i_req_rd = 5'd9;
      @(negedge clk);
      tests++;
      if (v2i_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_accept got %b, required 1", v2i_req_ready);
      end
      step();
      v2i_req_valid = 1'b0;
      i2v_req_valid = 1'b1;
      i2v_req_data = 32'hA5A5A5A5;
      i2v_req_vd = 5'd12;
      @(negedge clk);
      tests++;
      if (i2v_req_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_exec_ready got %b, required 0", i2v_req_ready);
      end
      step();
      @(negedge clk);
      snap_d = xwb_data;
      snap_r = xwb_rd;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         tests++;
         if ({xwb_valid, i2v_req_ready} !== 2'b10 || xwb_data !== snap_d
             || xwb_rd !== snap_r || xwb_data !== lo || xwb_rd !== 5'd9) begin
            fails++;
            $display("FAIL bp_hold%0d got xv=%b rdy=%b data=%h rd=%0d, required 1 0 %h 9",
                     i, xwb_valid, i2v_req_ready, xwb_data, xwb_rd, lo);
         end
         step();
      end
      xwb_ready = 1'b1;
      @(negedge clk);
      tests++;
      if ({xwb_valid, i2v_req_ready} !== 2'b11) begin
         fails++;
         $display("FAIL bp_release got xv=%b rdy=%b, required 1 1", xwb_valid, i2v_req_ready);
      end
      step();
      i2v_req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, alu_is_i2v, xwb_valid} !== 3'b110) begin
         fails++;
         $display("FAIL bp_chain got busy=%b i2v=%b xv=%b, required 1 1 0", busy, alu_is_i2v, xwb_valid);
      end
      step();
      wait_idle("bp");
   endtask

   task automatic test_flush();
      vwb_ready = 1'b1;
      xwb_ready = 1'b1;
      i2v_req_valid = 1'b1;
      i2v_req_data = 32'h0BADF00D;
      i2v_req_vd = 5'd5;
      @(negedge clk);
      step();
      i2v_req_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy, alu_is_i2v, i2v_req_ready} !== 3'b110) begin
         fails++;
         $display("FAIL flush_exec got busy=%b i2v=%b rdy=%b, required 1 1 0", busy, alu_is_i2v, i2v_req_ready);
      end
      step();
      flush = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, vwb_valid} !== 2'b00 || vwb_data !== '0) begin
         fails++;
         $display("FAIL flush_exec_after got busy=%b vv=%b data=%h, required 0 0 0", busy, vwb_valid, vwb_data);
      end
      step();
      xwb_ready = 1'b0;
      v2i_req_valid = 1'b1;
      v2i_req_data = {$urandom, $urandom, $urandom, $urandom};
      v2i_req_rd = 5'd11;
      @(negedge clk);
      step();
      v2i_req_valid = 1'b0;
      step();
      xwb_ready = 1'b1;
      flush = 1'b1;
      i2v_req_valid = 1'b1;
      v2i_req_valid = 1'b1;
      @(negedge clk);
      tests++;
      if ({xwb_valid, i2v_req_ready, v2i_req_ready} !== 3'b100) begin
         fails++;
         $display("FAIL flush_wb got xv=%b rdy=%b%b, required 1 0 0", xwb_valid, i2v_req_ready, v2i_req_ready);
      end
      step();
      flush = 1'b0;
      i2v_req_valid = 1'b0;
      v2i_req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, xwb_valid} !== 2'b00 || xwb_data !== '0 || xwb_rd !== '0) begin
         fails++;
         $display("FAIL flush_wb_after got busy=%b xv=%b data=%h rd=%0d, required 0 0 0 0",
                  busy, xwb_valid, xwb_data, xwb_rd);
      end
      step();
      flush = 1'b1;
      i2v_req_valid = 1'b1;
      i2v_req_data = 32'h13579BDF;
      i2v_req_vd = 5'd2;
      @(negedge clk);
      tests++;
      if (i2v_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_idle got rdy=%b, required 1", i2v_req_ready);
      end
      step();
      flush = 1'b0;
      i2v_req_valid = 1'b0;
      wait_idle("flush");
   endtask

   task automatic test_reset_mid_wb();
      vwb_ready = 1'b0;
      i2v_req_valid = 1'b1;
      i2v_req_data = 32'h55AA55AA;
      i2v_req_vd = 5'd6;
      @(negedge clk);
      step();
      i2v_req_valid = 1'b0;
      step();
      @(negedge clk);
      tests++;
      if (vwb_valid !== 1'b1) begin
         fails++;
         $display("FAIL rstwb_pending got vv=%b, required 1", vwb_valid);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vwb_ready = 1'b1;
      xwb_ready = 1'b1;
      i2v_req_valid = 1'b1;
      v2i_req_valid = 1'b1;
      i2v_req_data = 32'h2468ACE0;
      i2v_req_vd = 5'd14;
      v2i_req_data = {$urandom, $urandom, $urandom, $urandom};
      v2i_req_rd = 5'd15;
      @(negedge clk);
      tests++;
      if ({vwb_valid, busy} !== 2'b00 || vwb_data !== '0 || vwb_vd !== '0 || vwb_be !== '0) begin
         fails++;
         $display("FAIL rstwb_clear got vv=%b busy=%b data=%h vd=%0d be=%h, required all 0",
                  vwb_valid, busy, vwb_data, vwb_vd, vwb_be);
      end
      tests++;
      if ({i2v_req_ready, v2i_req_ready} !== 2'b10) begin
         fails++;
         $display("FAIL rstwb_grant got rdy=%b%b, required 1 0", i2v_req_ready, v2i_req_ready);
      end
      step();
      i2v_req_valid = 1'b0;
      step();
      @(negedge clk);
      tests++;
      if (v2i_req_ready !== 1'b1) begin
         fails++;
         $display("FAIL rstwb_next got rdy=%b, required 1", v2i_req_ready);
      end
      step();
      v2i_req_valid = 1'b0;
      wait_idle("rstwb");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_i2v();
      test_v2i();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid_wb();
      step();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/riscv_v_permutation_ctrl.md
Name: riscv_v_permutation_ctrl

Overview:
- Sequences the vector permutation ALU for scalar<->vector moves: vmv.s.x (i2v) and vmv.x.s (v2i).
- Arbitrates round-robin between an i2v requester and a v2i requester.
- Registers operands and drives the ALU controls, then captures the result and holds it on the scalar or vector writeback port until that port accepts it.
- Sits between the vector issue stage and the permutation ALU / writeback paths; one op in flight.

Parameters:
- DATA_W, RISCV_DATA_WIDTH (32): scalar data width.
- VLEN, RISCV_V_VLEN (128): vector ALU/writeback data width in bits; byte-valid width = VLEN/8.
- XREG_W, 5: scalar register index width.
- VREG_W, 5: vector register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i2v_req_valid  in  1  i2v request valid.
- i2v_req_ready  out  1  i2v request accepted this cycle.
- i2v_req_data  in  DATA_W  scalar rs1 value.
- i2v_req_vd  in  VREG_W  destination vector register.
- v2i_req_valid  in  1  v2i request valid.
- v2i_req_ready  out  1  v2i request accepted this cycle.
- v2i_req_data  in  VLEN  vs2 read data (element 0 in bits [DATA_W-1:0]).
- v2i_req_rd  in  XREG_W  destination scalar register.
- alu_is_i2v  out  1  to ALU is_i2v.
- alu_is_v2i  out  1  to ALU is_v2i.
- alu_int_in  out  DATA_W  to ALU integer_data_in.
- alu_vec_in  out  VLEN  to ALU vector_data_in.data.
- alu_int_out  in  DATA_W  from ALU integer_data_out.
- alu_vec_out_data  in  VLEN  from ALU vector_data_out.data.
- alu_vec_out_valid  in  VLEN/8  from ALU vector_data_out.valid.
- xwb_valid  out  1  scalar writeback valid.
- xwb_ready  in  1  scalar writeback ready.
- xwb_rd  out  XREG_W  scalar writeback index.
- xwb_data  out  DATA_W  scalar writeback data.
- vwb_valid  out  1  vector writeback valid.
- vwb_ready  in  1  vector writeback ready.
- vwb_vd  out  VREG_W  vector writeback index.
- vwb_data  out  VLEN  vector writeback data.
- vwb_be  out  VLEN/8  vector writeback byte enables.
- flush  in  1  kill the in-flight op.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE: accept one request, then go to EXEC.
  - EXEC: one cycle; drive the alu_is_* flag of the op kind and register the ALU outputs into the wb registers; go to WB.
  - WB: assert xwb_valid (v2i) or vwb_valid (i2v). Stay in WB until the selected ready is high. On handshake, return to IDLE, or go directly to EXEC if a new request is accepted in the same cycle.
- Request acceptance:
  - A request is accepted when the ctrl is in IDLE, or in WB with the handshake completing this cycle.
  - Acceptance requires the matching req_valid and a grant; the req_ready pulse marks acceptance.
  - At most one ready is high per cycle. Each ready depends only on state, the valids, wb ready and the RR pointer; no dependency on data.
- Arbitration:
  - If both requesters are valid, grant the one not granted last time (RR pointer).
  - The pointer updates only on acceptance. Reset value: i2v has priority.
- Operand and data registers:
  - Operands, kind and destination index are latched at acceptance and held to the end of WB.
  - alu_int_in and alu_vec_in are driven from the operand registers in EXEC, and zero otherwise.
  - alu_is_i2v and alu_is_v2i are mutually exclusive and high only in EXEC.
- Latency: accept at cycle T -> wb valid at T+2 if no stall. Peak throughput: 1 op per 2 cycles.
- Backpressure: while waiting in WB, the valid and all wb data/index outputs are held stable until ready.
- flush:
  - In EXEC or WB, flush returns the FSM to IDLE next cycle and drops the wb valid with no handshake.
  - flush has priority over a same-cycle ready and over a new acceptance; no req_ready is asserted in a flush cycle.
  - flush in IDLE has no effect.
- Reset, applied at the clk edge:
  - State goes to IDLE and the RR pointer to i2v-priority.
  - All valids, readys, alu_is_* and busy go to 0.
  - Data/index registers clear to 0.
  - Reset mid-WB drops the pending result.
- Unused wb port: its data, index and be are 0.
- Width rules:
  - The i2v result occupies bits [DATA_W-1:0]; vwb_be = low DATA_W/8 bits set, as produced by the ALU.
  - The v2i result is the low DATA_W bits of vs2.

Decomposition:
- The shared package (riscv_v_pkg) gains:
  - riscv_v_perm_kind_e {PERM_I2V, PERM_V2I};
  - riscv_v_perm_state_e {PERM_IDLE, PERM_EXEC, PERM_WB};
  - request structs riscv_v_perm_i2v_req_t and riscv_v_perm_v2i_req_t.
- The existing RISCV_DATA_WIDTH and BYTE_WIDTH constants are reused.
- One sub-module, riscv_v_rr_arb2: a 2-way round-robin arbiter with a grant pointer updated on accept. It is reusable by other vector units.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- i2v only: data=0xDEADBEEF, vd=3, vwb_ready=1 -> vwb_valid at T+2, vwb_data low word 0xDEADBEEF, upper 0, vwb_be=0x000F, vwb_vd=3, busy 1 for 2 cycles.
- v2i only: vs2 low word 0x12345678, upper bits 0xFF.., rd=7 -> xwb_valid at T+2, xwb_data=0x12345678, xwb_rd=7; alu_is_v2i high only in cycle T+1.
- Both requesters valid for 4 ops, wb ready=1 -> grants alternate i2v,v2i,i2v,v2i; ops accepted every 2 cycles via WB->EXEC back-to-back.
- xwb_ready low 5 cycles during v2i WB -> xwb_valid/data/rd stable for 5 cycles, no req_ready; on ready, the next op is accepted the same cycle.
- flush asserted in EXEC, then again in WB under stall with ready=1 -> no wb handshake, state IDLE next cycle, no acceptance in the flush cycle.
- rst asserted in WB with pending i2v -> next cycle vwb_valid=0, busy=0, outputs 0; first op after reset with both valid grants i2v.
